doc_reg_responder: RTL and testbench

// DOC-side responder for Sound GLU register cycles: owns the 5503 DOC register file and completes the host accesses the GLU

---
 rtl/doc_reg_responder.sv | 195 +++++++++++++++++++
 tb/tb_doc_reg_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/doc_reg_responder.sv
// DOC-side register responder for the Sound GLU. It holds the oscillator
// register file, the oscillator-enable byte, the halt-interrupt pending set,
// and two registered read ports: one for the host (GLU) and one for the
// synthesis engine.
module doc_reg_responder #(
    parameter logic [7:0] OSC_EN_RESET = 8'h02,
    parameter logic [7:0] UNMAPPED_RD  = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ram_access,
    input  logic        doc_wr,
    input  logic        doc_rd,
    input  logic [15:0] sound_addr,
    input  logic [7:0]  sound_data_out,
    output logic [7:0]  sound_data_in,
    input  logic [7:0]  eng_addr,
    output logic [7:0]  eng_data,
    input  logic        halt_valid,
    input  logic [4:0]  halt_num,
    output logic [5:0]  osc_count,
    output logic        irq_n
);

    localparam logic [7:0] ADDR_IRQ    = 8'hE0;
    localparam logic [7:0] ADDR_OSC_EN = 8'hE1;
    localparam logic [7:0] ADDR_AD     = 8'hE2;
    localparam logic [7:0] AD_VALUE    = 8'h80;
    localparam int         FILE_BYTES  = 224;

    // Lowest set bit index; the all-zero case reports 31 (only seen when
    // nothing is pending, where the caller substitutes 8'hFF anyway).
    function automatic logic [4:0] lowest_set(input logic [31:0] vec);
        logic [4:0] idx;
        idx = 5'd31;
        for (int i = 31; i >= 0; i--) begin
            idx = vec[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

    // Address decode of one read port, given the register-file byte at that address.
    function automatic logic [7:0] reg_read(input logic [7:0] addr,
                                            input logic [7:0] file_byte,
                                            input logic [7:0] irq_byte,
                                            input logic [7:0] osc_en);
        logic [7:0] val;
        if (addr < ADDR_IRQ) begin
            val = file_byte;
        end else begin
            case (addr)
                ADDR_IRQ:    val = irq_byte;
                ADDR_OSC_EN: val = osc_en;
                ADDR_AD:     val = AD_VALUE;
                default:     val = UNMAPPED_RD;
            endcase
        end
        return val;
    endfunction

    logic [7:0]  r_regs [0:FILE_BYTES-1];
    logic [7:0]  r_osc_en;
    logic [31:0] r_pending;
    logic [4:0]  r_irq_num;
    logic [7:0]  r_sound_data_in;
    logic [7:0]  r_eng_data;
    logic        r_irq_n;

    logic [7:0]  w_addr;
    logic        w_unused_addr_hi;
    logic        w_wr_en;
    logic        w_wr_file;
    logic        w_wr_osc;
    logic        w_wr_any;
    logic [7:0]  w_ctl_idx;
    logic        w_halt_ie;
    logic [31:0] w_set_mask;
    logic        w_clr;
    logic [31:0] w_clr_mask;
    logic [7:0]  w_irq_byte;
    logic [7:0]  w_wr_val;
    logic [7:0]  w_host_rd;
    logic [7:0]  w_eng_rd;

    assign w_addr           = sound_addr[7:0];
    assign w_unused_addr_hi = ^sound_addr[15:8];
    assign w_wr_en          = doc_wr & ~ram_access;
    assign w_wr_file        = w_wr_en & (w_addr < ADDR_IRQ);
    assign w_wr_osc         = w_wr_en & (w_addr == ADDR_OSC_EN);
    assign w_wr_any         = w_wr_file | w_wr_osc;

    // Control byte of the halting oscillator lives at A0 + n.
    assign w_ctl_idx  = {3'b101, halt_num};
    // IE is taken from the stored byte, i.e. before any same-cycle host write.
    assign w_halt_ie  = r_regs[w_ctl_idx][3];
    assign w_set_mask = (halt_valid & w_halt_ie) ? (32'd1 << halt_num) : 32'd0;

    assign w_clr      = doc_rd & ~ram_access & (w_addr == ADDR_IRQ) & (|r_pending);
    assign w_clr_mask = w_clr ? (32'd1 << r_irq_num) : 32'd0;

    assign w_irq_byte = (|r_pending) ? {1'b0, 1'b1, lowest_set(r_pending), 1'b1} : 8'hFF;

    // Value the written byte will hold after this edge, including a
    // colliding halt that forces the halt bit of the same control byte.
    always_comb begin
        w_wr_val = sound_data_out;
        if (halt_valid && (w_addr == w_ctl_idx)) begin
            w_wr_val[0] = 1'b1;
        end else begin
            w_wr_val[0] = sound_data_out[0];
        end
    end

    // Host read mux; a same-cycle write to the read address forwards the new value.
    always_comb begin
        w_host_rd = 8'h00;
        if (w_wr_any) begin
            w_host_rd = w_wr_val;
        end else begin
            w_host_rd = reg_read(w_addr, r_regs[w_addr], w_irq_byte, r_osc_en);
        end
    end

    // Engine read mux with the same write-forwarding rule as the host port.
    always_comb begin
        w_eng_rd = 8'h00;
        if (w_wr_any && (eng_addr == w_addr)) begin
            w_eng_rd = w_wr_val;
        end else begin
            w_eng_rd = reg_read(eng_addr, r_regs[eng_addr], w_irq_byte, r_osc_en);
        end
    end

    // Register file: host writes, then the halt bit is forced so it wins over bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FILE_BYTES; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (w_wr_file) begin
                r_regs[w_addr] <= sound_data_out;
            end
            if (halt_valid) begin
                r_regs[w_ctl_idx][0] <= 1'b1;
            end
        end
    end

    // Oscillator-enable byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_osc_en <= OSC_EN_RESET;
        end else if (w_wr_osc) begin
            r_osc_en <= sound_data_out;
        end
    end

    // Pending halt interrupts: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    // Remember which oscillator the last E0 read reported; that is the one a read-complete clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_num <= 5'd0;
        end else if (w_addr == ADDR_IRQ) begin
            r_irq_num <= w_irq_byte[5:1];
        end
    end

    // Registered read data for both ports and the interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sound_data_in <= 8'h00;
            r_eng_data      <= 8'h00;
            r_irq_n         <= 1'b1;
        end else begin
            r_sound_data_in <= w_host_rd;
            r_eng_data      <= w_eng_rd;
            r_irq_n         <= ~(|r_pending);
        end
    end

    assign sound_data_in = r_sound_data_in;
    assign eng_data      = r_eng_data;
    assign irq_n         = r_irq_n;
    assign osc_count     = {1'b0, r_osc_en[5:1]} + 6'd1;

endmodule

// File: tb/tb_doc_reg_responder.sv
// Bench for doc_reg_responder: a directed vector table, a reset-during-write
// sequence, then randomized cycles checked against an array-based model.
module tb_doc_reg_responder;

    logic        clk;
    logic        reset_n;
    logic        ram_access;
    logic        doc_wr;
    logic        doc_rd;
    logic [15:0] sound_addr;
    logic [7:0]  sound_data_out;
    logic [7:0]  sound_data_in;
    logic [7:0]  eng_addr;
    logic [7:0]  eng_data;
    logic        halt_valid;
    logic [4:0]  halt_num;
    logic [5:0]  osc_count;
    logic        irq_n;

    int errors = 0;
    int checks = 0;

    doc_reg_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ram_access     (ram_access),
        .doc_wr         (doc_wr),
        .doc_rd         (doc_rd),
        .sound_addr     (sound_addr),
        .sound_data_out (sound_data_out),
        .sound_data_in  (sound_data_in),
        .eng_addr       (eng_addr),
        .eng_data       (eng_data),
        .halt_valid     (halt_valid),
        .halt_num       (halt_num),
        .osc_count      (osc_count),
        .irq_n          (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       ram;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] eaddr;
        logic       hv;
        logic [4:0] hn;
        logic [7:0] exp_sd;
        logic [7:0] exp_eng;
        logic       exp_irqn;
        logic [5:0] exp_osc;
    } vec_t;

    // Reference state: a flat 256-byte map, a pending bit set and the last reported osc.
    logic [7:0]  m_mem [0:255];
    logic [31:0] m_pend;
    logic [4:0]  m_irqnum;

    function automatic vec_t mk(input logic wr, input logic rd, input logic ram,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] eaddr, input logic hv, input logic [4:0] hn,
                                input logic [7:0] sd, input logic [7:0] eng,
                                input logic irqn, input logic [5:0] osc);
        vec_t v;
        v.wr = wr; v.rd = rd; v.ram = ram; v.addr = addr; v.wdata = wdata;
        v.eaddr = eaddr; v.hv = hv; v.hn = hn; v.exp_sd = sd; v.exp_eng = eng;
        v.exp_irqn = irqn; v.exp_osc = osc;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_mem[8'hE1] = 8'h02;
        m_pend       = 32'd0;
        m_irqnum     = 5'd0;
    endtask

    function automatic logic [7:0] m_e0();
        logic [4:0] n;
        n = 5'd0;
        if (m_pend == 32'd0) return 8'hFF;
        for (int i = 31; i >= 0; i--) if (m_pend[i]) n = 5'(i);
        return {2'b01, n, 1'b1};
    endfunction

    function automatic logic [7:0] m_rd(input logic [7:0] a);
        if (a < 8'hE0) return m_mem[a];
        if (a == 8'hE0) return m_e0();
        if (a == 8'hE1) return m_mem[8'hE1];
        if (a == 8'hE2) return 8'h80;
        return 8'h00;
    endfunction

    // Advance the model by one clock and produce the outputs expected after that edge.
    task automatic model_step(input vec_t v, output vec_t e);
        logic       wr_ok;
        logic       ie;
        logic       clr;
        logic [7:0] pre_sd;
        logic [7:0] pre_eng;
        logic [7:0] ctl;
        logic [7:0] e0v;
        logic [7:0] osc_en;
        e          = v;
        wr_ok      = v.wr && !v.ram && ((v.addr < 8'hE0) || (v.addr == 8'hE1));
        e.exp_irqn = (m_pend == 32'd0);
        pre_sd     = m_rd(v.addr);
        pre_eng    = m_rd(v.eaddr);
        ctl        = 8'hA0 + {3'b000, v.hn};
        ie         = m_mem[ctl][3];
        e0v        = m_e0();
        clr        = v.rd && !v.ram && (v.addr == 8'hE0) && (m_pend != 32'd0);
        if (wr_ok) m_mem[v.addr] = v.wdata;
        if (v.hv) m_mem[ctl][0] = 1'b1;
        if (clr) m_pend[m_irqnum] = 1'b0;
        if (v.hv && ie) m_pend[v.hn] = 1'b1;
        if (v.addr == 8'hE0) m_irqnum = e0v[5:1];
        e.exp_sd  = wr_ok ? m_mem[v.addr] : pre_sd;
        e.exp_eng = (wr_ok && (v.eaddr == v.addr)) ? m_mem[v.addr] : pre_eng;
        osc_en    = m_mem[8'hE1];
        e.exp_osc = {1'b0, osc_en[5:1]} + 6'd1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, step the model, and wait until just after the edge.
    task automatic apply(input vec_t v, output vec_t e);
        doc_wr         = v.wr;
        doc_rd         = v.rd;
        ram_access     = v.ram;
        sound_addr     = {8'($urandom_range(0, 255)), v.addr};
        sound_data_out = v.wdata;
        eng_addr       = v.eaddr;
        halt_valid     = v.hv;
        halt_num       = v.hn;
        model_step(v, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        doc_wr = 1'b0; doc_rd = 1'b0; ram_access = 1'b0; sound_addr = 16'h0000;
        sound_data_out = 8'h00; eng_addr = 8'h00; halt_valid = 1'b0; halt_num = 5'd0;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t e;
        vec_t v;
        logic [7:0] a;
        int sel;

        //       wr    rd    ram   addr   wdata  eaddr  hv    hn     sd     eng    irqn  osc
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE1, 8'h00, 8'hE1, 1'b0, 5'd0, 8'h02, 8'h02, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h47, 8'h5A, 8'h47, 1'b0, 5'd0, 8'h5A, 8'h5A, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h47, 8'h00, 8'h47, 1'b0, 5'd0, 8'h5A, 8'h5A, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA3, 8'h08, 8'h00, 1'b0, 5'd0, 8'h08, 8'h00, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA3, 8'h00, 8'hA3, 1'b1, 5'd3, 8'h08, 8'h08, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA3, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h09, 8'h47, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h47, 8'h47, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h47, 8'h47, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'hFF, 8'hFF, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA9, 8'h08, 8'h00, 1'b0, 5'd0, 8'h08, 8'h00, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA2, 8'h08, 8'hA2, 1'b0, 5'd0, 8'h08, 8'h08, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b1, 5'd9, 8'hFF, 8'hFF, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b1, 5'd2, 8'h53, 8'h53, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h45, 8'h45, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h45, 8'h45, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h53, 8'h53, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h53, 8'h53, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'hFF, 8'hFF, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA5, 8'h08, 8'hA5, 1'b0, 5'd0, 8'h08, 8'h08, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b1, 5'd5, 8'h01, 8'h01, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h01, 8'h4B, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h4B, 8'h4B, 1'b0, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA5, 8'h08, 8'hA5, 1'b0, 5'd0, 8'h08, 8'h08, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h4B, 8'h4B, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b1, 5'd5, 8'h4B, 8'h4B, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h4B, 8'h4B, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'h4B, 8'h4B, 1'b0, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE0, 8'h00, 8'hE0, 1'b0, 5'd0, 8'hFF, 8'hFF, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 8'h10, 8'h77, 8'h10, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hE0, 8'h12, 8'hE0, 1'b0, 5'd0, 8'hFF, 8'hFF, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hE3, 8'h34, 8'hE3, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 6'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'hE2, 8'h00, 8'hE2, 1'b0, 5'd0, 8'h80, 8'h80, 1'b1, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hE1, 8'h3E, 8'hE1, 1'b0, 5'd0, 8'h3E, 8'h3E, 1'b1, 6'd32));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hE1, 8'h00, 8'hE1, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 6'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'hE1, 8'h02, 8'hE1, 1'b0, 5'd0, 8'h02, 8'h02, 1'b1, 6'd2));

        // Reset state.
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset sd", sound_data_in, 8'h00);
        check("reset eng", eng_data, 8'h00);
        check("reset irq_n", {7'd0, irq_n}, 8'h01);
        check("reset osc_count", {2'd0, osc_count}, 8'h02);
        reset_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], e);
            check($sformatf("row%0d sd", i), sound_data_in, tbl[i].exp_sd);
            check($sformatf("row%0d eng", i), eng_data, tbl[i].exp_eng);
            check($sformatf("row%0d irq_n", i), {7'd0, irq_n}, {7'd0, tbl[i].exp_irqn});
            check($sformatf("row%0d osc", i), {2'd0, osc_count}, {2'd0, tbl[i].exp_osc});
        end

        // Reset asserted in the middle of a write: the write must not land.
        doc_wr = 1'b1; sound_addr = 16'h0000; sound_data_out = 8'hAA; eng_addr = 8'h00;
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst sd", sound_data_in, 8'h00);
        check("midrst irq_n", {7'd0, irq_n}, 8'h01);
        idle_inputs();
        reset_n = 1'b1;
        model_reset();
        v = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 6'd2);
        apply(v, e);
        check("midrst read00", sound_data_in, 8'h00);
        check("midrst osc", {2'd0, osc_count}, 8'h02);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       a = 8'hA0 + 8'($urandom_range(0, 31));
            else if (sel < 6)  a = 8'hE0;
            else if (sel == 6) a = 8'hE1;
            else               a = 8'($urandom_range(0, 255));
            v.addr  = a;
            v.wr    = ($urandom_range(0, 3) == 0);
            v.rd    = (a == 8'hE0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            v.ram   = ($urandom_range(0, 7) == 0);
            v.wdata = 8'($urandom_range(0, 255));
            v.eaddr = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 255));
            v.hv    = ($urandom_range(0, 2) == 0);
            v.hn    = 5'($urandom_range(0, 31));
            apply(v, e);
            check($sformatf("rnd%0d sd", n), sound_data_in, e.exp_sd);
            check($sformatf("rnd%0d eng", n), eng_data, e.exp_eng);
            check($sformatf("rnd%0d irq_n", n), {7'd0, irq_n}, {7'd0, e.exp_irqn});
            check($sformatf("rnd%0d osc", n), {2'd0, osc_count}, {2'd0, e.exp_osc});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
